// File: rtl/conv_loop_seq_pkg.sv
// Shared types for the convolution loop sequencer.
// Optional feature macro: CONV_PERF_CNT_EN (see conv_loop_seq.sv).
package conv_loop_seq_pkg;

    localparam int LOOP_BIT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOP,
        ST_BIAS,
        ST_DRAIN,
        ST_WB
    } state_t;

    typedef logic [LOOP_BIT_DEF-1:0] idx_t;

endpackage

// File: rtl/conv_loop_seq_if.sv
// Controller / MAC-array facing bundle of the loop sequencer.
// master = layer controller side, slave = sequencer.
interface conv_loop_seq_if
    import conv_loop_seq_pkg::*;
#(
    parameter int LOOP_BIT = LOOP_BIT_DEF,
    parameter int PERF_BIT = 32
);
    logic                start;
    logic                wb_ack;
    logic [LOOP_BIT-1:0] cfg_R;
    logic [LOOP_BIT-1:0] cfg_C;
    logic [LOOP_BIT-1:0] cfg_M;
    logic [LOOP_BIT-1:0] cfg_N;
    logic [LOOP_BIT-1:0] cfg_K;
    logic                busy;
    logic                done;
    logic                loop_en;
    logic [LOOP_BIT-1:0] rr;
    logic [LOOP_BIT-1:0] cc;
    logic [LOOP_BIT-1:0] mm;
    logic [LOOP_BIT-1:0] nn;
    logic [LOOP_BIT-1:0] ii;
    logic [LOOP_BIT-1:0] jj;
    logic                unit_en_dly;
    logic                set_b_dly;
    logic [PERF_BIT-1:0] perf_cycles;

    modport master (
        output start, wb_ack, cfg_R, cfg_C, cfg_M, cfg_N, cfg_K,
        input  busy, done, loop_en, rr, cc, mm, nn, ii, jj,
        input  unit_en_dly, set_b_dly, perf_cycles
    );

    modport slave (
        input  start, wb_ack, cfg_R, cfg_C, cfg_M, cfg_N, cfg_K,
        output busy, done, loop_en, rr, cc, mm, nn, ii, jj,
        output unit_en_dly, set_b_dly, perf_cycles
    );
endinterface

// File: rtl/conv_loop_seq_dly.sv
// Single-bit fixed-length shift register with synchronous clear,
// matching the MAC-array pipeline depth.
module conv_dly_line #(
    parameter int DLY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    logic [DLY-1:0] sr;

    // shift one stage per cycle; rst flushes every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DLY; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DLY-1];
endmodule

// File: rtl/conv_loop_seq.sv
// Convolution loop sequencer: owns rr/cc/mm/nn/ii/jj and the run FSM.
// CONV_PERF_CNT_EN adds a busy-cycle counter on perf_cycles.
module conv_loop_seq
    import conv_loop_seq_pkg::*;
#(
    parameter int LOOP_BIT = LOOP_BIT_DEF,
    parameter int PIPE_DLY = 2,
    parameter int PERF_BIT = 32
) (
    input  logic            clk,
    input  logic            rst,
    conv_loop_seq_if.slave  bus
);
    localparam logic [LOOP_BIT-1:0] ONE = LOOP_BIT'(1);

    state_t state, state_nxt;
    logic [LOOP_BIT-1:0] r_q, c_q, m_q, n_q, k_q;
    logic [LOOP_BIT-1:0] rr, cc, mm, nn, ii, jj;
    logic [3:0] dcnt;
    logic cfg_ok, go, inner_last, outer_last, drain_last;
    logic unit_en, set_b, ue_d, sb_d;

    assign cfg_ok = (bus.cfg_R != '0) && (bus.cfg_C != '0) &&
                    (bus.cfg_M != '0) && (bus.cfg_N != '0) &&
                    (bus.cfg_K != '0);
    assign go = (state == ST_IDLE) && bus.start && cfg_ok;

    assign inner_last = (nn == n_q - ONE) && (ii == k_q - ONE) &&
                        (jj == k_q - ONE);
    assign outer_last = (rr == r_q - ONE) && (cc == c_q - ONE) &&
                        (mm == m_q - ONE);
    assign drain_last = (dcnt == 4'(PIPE_DLY - 1));

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // next-state and Moore strobes
    always_comb begin
        state_nxt = state;
        unit_en   = 1'b0;
        set_b     = 1'b0;
        unique case (state)
            ST_IDLE:  if (go) state_nxt = ST_LOOP;
            ST_LOOP: begin
                unit_en = 1'b1;
                if (inner_last) state_nxt = ST_BIAS;
            end
            ST_BIAS: begin
                unit_en   = 1'b1;
                set_b     = 1'b1;
                state_nxt = outer_last ? ST_DRAIN : ST_LOOP;
            end
            ST_DRAIN: if (drain_last) state_nxt = ST_WB;
            ST_WB:    if (bus.wb_ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // cfg latch, nested loop counters and drain timer
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_q, c_q, m_q, n_q, k_q} <= '0;
            {rr, cc, mm, nn, ii, jj}  <= '0;
            dcnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        r_q <= bus.cfg_R;
                        c_q <= bus.cfg_C;
                        m_q <= bus.cfg_M;
                        n_q <= bus.cfg_N;
                        k_q <= bus.cfg_K;
                        {rr, cc, mm, nn, ii, jj} <= '0;
                    end
                end
                ST_LOOP: begin
                    if (jj == k_q - ONE) begin
                        jj <= '0;
                        if (ii == k_q - ONE) begin
                            ii <= '0;
                            nn <= (nn == n_q - ONE) ? '0 : nn + ONE;
                        end else begin
                            ii <= ii + ONE;
                        end
                    end else begin
                        jj <= jj + ONE;
                    end
                end
                ST_BIAS: begin
                    dcnt <= '0;
                    if (mm == m_q - ONE) begin
                        mm <= '0;
                        if (cc == c_q - ONE) begin
                            cc <= '0;
                            rr <= (rr == r_q - ONE) ? '0 : rr + ONE;
                        end else begin
                            cc <= cc + ONE;
                        end
                    end else begin
                        mm <= mm + ONE;
                    end
                end
                ST_DRAIN: dcnt <= dcnt + 4'd1;
                default: ;
            endcase
        end
    end

    conv_dly_line #(.DLY(PIPE_DLY)) u_ue_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (unit_en),
        .dout (ue_d)
    );

    conv_dly_line #(.DLY(PIPE_DLY)) u_sb_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (set_b),
        .dout (sb_d)
    );

    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_IDLE);
    assign bus.loop_en     = (state == ST_LOOP);
    assign bus.rr          = rr;
    assign bus.cc          = cc;
    assign bus.mm          = mm;
    assign bus.nn          = nn;
    assign bus.ii          = ii;
    assign bus.jj          = jj;
    assign bus.unit_en_dly = ue_d;
    assign bus.set_b_dly   = sb_d;

`ifdef CONV_PERF_CNT_EN
    logic [PERF_BIT-1:0] perf;

    // busy-cycle count, restarted by an accepted start
    always_ff @(posedge clk) begin
        if (rst)                    perf <= '0;
        else if (go)                perf <= '0;
        else if (state != ST_IDLE)  perf <= perf + PERF_BIT'(1);
    end

    assign bus.perf_cycles = perf;
`else
    assign bus.perf_cycles = {PERF_BIT{1'b0}};
`endif

endmodule

// File: tb/tb_conv_loop_seq.sv
// Self-checking bench for conv_loop_seq: queue-based run model plus
// hand-computed timing literals from directed scenarios.
module tb_conv_loop_seq;

    localparam int PIPE_DLY = 2;
    localparam logic [2:0] K_IDLE  = 3'd0;
    localparam logic [2:0] K_LOOP  = 3'd1;
    localparam logic [2:0] K_BIAS  = 3'd2;
    localparam logic [2:0] K_DRAIN = 3'd3;
    localparam logic [2:0] K_WB    = 3'd4;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] rr, cc, mm, nn, ii, jj;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    conv_loop_seq_if #(.LOOP_BIT(8), .PERF_BIT(32)) bus ();

    conv_loop_seq #(
        .LOOP_BIT (8),
        .PIPE_DLY (PIPE_DLY),
        .PERF_BIT (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model ----------------
    step_t q[$];
    step_t cur;
    bit    ue_h[$];
    bit    sb_h[$];
    int    m_perf;

    task automatic build_run(int R, int C, int M, int N, int K);
        step_t s;
        q.delete();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                for (int m = 0; m < M; m++) begin
                    for (int n = 0; n < N; n++)
                        for (int i = 0; i < K; i++)
                            for (int j = 0; j < K; j++) begin
                                s = '{K_LOOP, 8'(r), 8'(c), 8'(m),
                                      8'(n), 8'(i), 8'(j)};
                                q.push_back(s);
                            end
                    s = '{K_BIAS, 8'(r), 8'(c), 8'(m), 8'd0, 8'd0, 8'd0};
                    q.push_back(s);
                end
        for (int d = 0; d < PIPE_DLY; d++) begin
            s = '0;
            s.kind = K_DRAIN;
            q.push_back(s);
        end
    endtask

    initial begin
        cur = '0;
        m_perf = 0;
        for (int d = 0; d < PIPE_DLY; d++) begin
            ue_h.push_back(1'b0);
            sb_h.push_back(1'b0);
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                cur = '0;
                q.delete();
                m_perf = 0;
                for (int d = 0; d < PIPE_DLY; d++) begin
                    ue_h[d] = 1'b0;
                    sb_h[d] = 1'b0;
                end
            end else begin
                ue_h.push_back(cur.kind == K_LOOP || cur.kind == K_BIAS);
                void'(ue_h.pop_front());
                sb_h.push_back(cur.kind == K_BIAS);
                void'(sb_h.pop_front());
                if (cur.kind != K_IDLE) m_perf++;
                if (cur.kind == K_IDLE) begin
                    if (bus.start && bus.cfg_R != 0 && bus.cfg_C != 0 &&
                        bus.cfg_M != 0 && bus.cfg_N != 0 && bus.cfg_K != 0) begin
                        build_run(int'(bus.cfg_R), int'(bus.cfg_C),
                                  int'(bus.cfg_M), int'(bus.cfg_N),
                                  int'(bus.cfg_K));
                        cur = q.pop_front();
                        m_perf = 0;
                    end
                end else if (cur.kind == K_WB) begin
                    if (bus.wb_ack) cur = '0;
                end else if (q.size() > 0) begin
                    cur = q.pop_front();
                end else begin
                    cur = '0;
                    cur.kind = K_WB;
                end
            end
        end
    end

    function automatic logic [31:0] exp_perf();
`ifdef CONV_PERF_CNT_EN
        return 32'(m_perf);
`else
        return 32'd0;
`endif
    endfunction

    // ---------------- per-cycle compare ----------------
    logic [84:0] exp_v, got_v;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_v = {cur.kind != K_IDLE, cur.kind == K_IDLE,
                         cur.kind == K_LOOP, ue_h[0], sb_h[0],
                         cur.rr, cur.cc, cur.mm, cur.nn, cur.ii, cur.jj,
                         exp_perf()};
                got_v = {bus.busy, bus.done, bus.loop_en,
                         bus.unit_en_dly, bus.set_b_dly,
                         bus.rr, bus.cc, bus.mm, bus.nn, bus.ii, bus.jj,
                         bus.perf_cycles};
                tests++;
                if (got_v !== exp_v) begin
                    fails++;
                    $display("FAIL cycle_cmp @%0d: got %h required %h",
                             cyc, got_v, exp_v);
                end
            end
        end
    end

    // ---------------- event recorder ----------------
    int t0 = 0;
    int loop_cnt, first_loop, last_loop, done_t;
    int sbd_q[$];
    int ued_q[$];
    bit done_prev;

    task automatic clr_rec();
        loop_cnt = 0;
        first_loop = -1;
        last_loop = -1;
        done_t = -1;
        sbd_q.delete();
        ued_q.delete();
        done_prev = 1'b1;
    endtask

    initial begin
        int off;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                off = cyc - t0;
                if (bus.loop_en) begin
                    if (loop_cnt == 0) first_loop = off;
                    last_loop = off;
                    loop_cnt++;
                end
                if (bus.set_b_dly)   sbd_q.push_back(off);
                if (bus.unit_en_dly) ued_q.push_back(off);
                if (bus.done && !done_prev && done_t < 0) done_t = off;
                done_prev = bus.done;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(string name, int got, int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic set_cfg(int R, int C, int M, int N, int K);
        bus.cfg_R = 8'(R);
        bus.cfg_C = 8'(C);
        bus.cfg_M = 8'(M);
        bus.cfg_N = 8'(N);
        bus.cfg_K = 8'(K);
    endtask

    task automatic do_start();
        @(negedge clk);
        clr_rec();
        t0 = cyc;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_off(int off);
        while (cyc - t0 < off) @(negedge clk);
    endtask

    task automatic wait_wb(int budget);
        int n = 0;
        while (cur.kind != K_WB && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wb_reached", int'(cur.kind == K_WB), 1);
    endtask

    task automatic pulse_ack();
        bus.wb_ack = 1'b1;
        @(negedge clk);
        bus.wb_ack = 1'b0;
    endtask

    function automatic int qat(int qq[$], int idx);
        return (idx < qq.size()) ? qq[idx] : -1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bus.start = 1'b0;
        bus.wb_ack = 1'b0;
        set_cfg(1, 1, 1, 1, 1);
        clr_rec();
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_done", int'(bus.done), 1);
        check("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;

        // all cfg = 1
        set_cfg(1, 1, 1, 1, 1);
        do_start();
        wait_off(7);
        pulse_ack();
        @(negedge clk);
        check("t1_loop_cnt", loop_cnt, 1);
        check("t1_first_loop", first_loop, 1);
        check("t1_sbd_n", sbd_q.size(), 1);
        check("t1_sbd0", qat(sbd_q, 0), 4);
        check("t1_ued_n", ued_q.size(), 2);
        check("t1_ued0", qat(ued_q, 0), 3);
        check("t1_ued1", qat(ued_q, 1), 4);
        check("t1_done_t", done_t, 8);

        // R=1 C=1 M=2 N=2 K=2
        set_cfg(1, 1, 2, 2, 2);
        do_start();
        wait_wb(100);
        check("t2_loop_cnt", loop_cnt, 16);
        check("t2_first_loop", first_loop, 1);
        check("t2_last_loop", last_loop, 17);
        check("t2_sbd_n", sbd_q.size(), 2);
        check("t2_sbd0", qat(sbd_q, 0), 11);
        check("t2_sbd1", qat(sbd_q, 1), 20);
        pulse_ack();
        repeat (2) @(negedge clk);

        // zero cfg ignored
        set_cfg(2, 2, 2, 2, 0);
        do_start();
        repeat (5) @(negedge clk);
        check("z_loop_cnt", loop_cnt, 0);
        check("z_busy", int'(bus.busy), 0);
        check("z_done", int'(bus.done), 1);

        // protocol: stray start/wb_ack, cfg change mid-run, perf
        set_cfg(2, 2, 2, 2, 2);
        do_start();
        wait_off(5);
        set_cfg(1, 1, 1, 1, 1);
        bus.start = 1'b1;
        bus.wb_ack = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wb_ack = 1'b0;
        wait_off(78);
        bus.start = 1'b1;
        bus.wb_ack = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wb_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("p_loop_cnt", loop_cnt, 64);
        check("p_last_loop", last_loop, 71);
        check("p_sbd_n", sbd_q.size(), 8);
        check("p_sbd_last", qat(sbd_q, 7), 74);
        check("p_done_t", done_t, 79);
        check("p_idle_busy", int'(bus.busy), 0);
`ifdef CONV_PERF_CNT_EN
        check("p_perf", int'(bus.perf_cycles), 78);
`else
        check("p_perf_tied", int'(bus.perf_cycles), 0);
`endif

        // reset mid-run
        set_cfg(2, 2, 2, 2, 2);
        do_start();
        wait_off(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("r_done", int'(bus.done), 1);
        check("r_busy", int'(bus.busy), 0);
        check("r_loop_en", int'(bus.loop_en), 0);
        check("r_cnt", int'({bus.rr, bus.cc, bus.mm,
                             bus.nn, bus.ii, bus.jj} != 0), 0);
        check("r_ued", int'(bus.unit_en_dly), 0);
        check("r_sbd", int'(bus.set_b_dly), 0);
        set_cfg(1, 1, 1, 1, 1);
        do_start();
        wait_wb(50);
        check("r2_loop_cnt", loop_cnt, 1);
        check("r2_sbd0", qat(sbd_q, 0), 4);
        pulse_ack();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_loop_seq.md
Name: conv_loop_seq

Overview:
Next-generation convolution loop sequencer. It owns the six loop counters (rr, cc, mm, nn, ii, jj) instead of receiving them from an external address generator. Loop bounds come from run-time configuration, and the output-pipeline delay is a parameter. It sits between the layer-level controller (start / write-back acknowledge) and the MAC array plus bias unit, which consume loop_en, unit_en_dly and set_b_dly.

Parameters:
LOOP_BIT, 8, width of every loop counter and loop-bound input
PIPE_DLY, 2, cycles of delay applied to unit_en and set_b (1..8); equals MAC-array pipeline depth
PERF_BIT, 32, width of the performance counter (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  run request; sampled only in ST_IDLE
wb_ack  in  1  write-back of last result complete
cfg_R, cfg_C, cfg_M, cfg_N, cfg_K  in  LOOP_BIT each  output rows/cols/channels, input channels, kernel size
busy  out  1  high from accepted start until done rises
done  out  1  run finished and written back
loop_en  out  1  current counter tuple is a valid MAC step
rr, cc, mm, nn, ii, jj  out  LOOP_BIT each  current loop indices
unit_en_dly  out  1  unit_en delayed by PIPE_DLY
set_b_dly  out  1  set_b (bias strobe) delayed by PIPE_DLY
perf_cycles  out  PERF_BIT  cycles of the last run (PERF_CNT_EN only)

Behaviour:
- Reset (synchronous, takes effect on the next edge, including mid-run):
  - state ST_IDLE, done=1, all other outputs 0
  - counters 0, delay lines cleared
- States: ST_IDLE, ST_LOOP, ST_BIAS, ST_DRAIN, ST_WB.
- ST_IDLE:
  - start=1 with every cfg value nonzero: latch cfg; next cycle state ST_LOOP, loop_en=1, unit_en=1, busy=1, done=0, counters 0.
  - start=1 with any cfg value zero: ignored; done stays 1.
- ST_LOOP: one MAC step per cycle.
  - jj is fastest, then ii (wraps at K-1), then nn (wraps at N-1).
  - Tuple nn=N-1, ii=K-1, jj=K-1: next cycle ST_BIAS, loop_en=0, set_b=1.
- ST_BIAS: one cycle.
  - set_b returns to 0 next cycle; inner counters return to 0.
  - Outer tuple advances: mm fastest, then cc, then rr.
  - If the finished tuple was rr=R-1, cc=C-1, mm=M-1: go ST_DRAIN with unit_en=0 and counters wrapped to 0.
  - Otherwise: back to ST_LOOP with loop_en=1.
- Each output point costs N*K*K+1 cycles; a run costs R*C*M*(N*K*K+1) cycles from the first loop_en cycle to ST_DRAIN entry.
- ST_DRAIN: hold PIPE_DLY cycles so the final set_b_dly and the unit_en_dly fall edge emerge; then ST_WB.
- ST_WB: on wb_ack, done=1 and busy=0 next cycle, state ST_IDLE. wb_ack in any other state is ignored.
- start outside ST_IDLE is ignored; it is not queued.
- start and wb_ack in the same ST_WB cycle: wb_ack honoured, start dropped.
- Delay lines: PIPE_DLY-stage shift registers clocked every cycle, cleared by rst.
- Counter compares use the latched cfg only. Mid-run cfg changes have no effect.

Optional Feature:
CONV_PERF_CNT_EN
- Defined: perf_cycles counts every cycle with busy=1; it is cleared at accepted start and holds its value after done.
- Undefined: perf_cycles is tied to 0 and no counter logic is generated.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE..ST_WB
  - LOOP_BIT default
  - a loop-index typedef of width LOOP_BIT
- One natural sub-module: conv_dly_line, a parametrised single-bit PIPE_DLY shift register with sync reset. It is instantiated twice, for unit_en and set_b.

Test Plan:
- All cfg=1, PIPE_DLY=2, start at cycle 0:
  - loop_en high cycle 1 only; set_b internal cycle 2; set_b_dly cycle 4
  - unit_en_dly high cycles 3..4
  - wb_ack at cycle 7 -> done=1 at cycle 8
- R=1, C=1, M=2, N=2, K=2: loop_en high cycles 1..8 and 10..17 → set_b_dly pulses at cycles 11 and 20 → counters jj,ii,nn,mm sequence matches nested order exactly.
- Zero cfg: start with cfg_K=0 -> done stays 1, busy stays 0, loop_en never rises.
- Protocol: start pulsed during ST_LOOP and wb_ack pulsed during ST_LOOP -> both ignored; run length unchanged (R=C=M=N=K=2 gives 72 loop cycles).
- Reset mid-run: rst at the 5th loop cycle -> next cycle done=1, loop_en=0, counters 0, delay outputs 0; a new start runs cleanly.
- CONV_PERF_CNT_EN, all cfg=2, wb_ack 3 cycles after ST_WB entry -> perf_cycles = 72+2+3+1 = 78.
